// File: rtl/simple_memory_device_if.sv
// Controller-to-memory bus: request strobes and address from the controller,
// registered read data, ready and error flag from the memory device.
interface simple_memory_device_if #(
  parameter int size = 16
);
  logic            mem_cs;
  logic            mem_read;
  logic [size-1:0] mem_addr_bus;
  logic [size-1:0] mem_data_bus;
  logic            mem_ready;
  logic            mem_err;

  modport master (
    output mem_cs, mem_read, mem_addr_bus,
    input  mem_data_bus, mem_ready, mem_err
  );

  modport slave (
    input  mem_cs, mem_read, mem_addr_bus,
    output mem_data_bus, mem_ready, mem_err
  );
endinterface

// File: rtl/simple_memory_device.sv
// Synchronous memory target with a fixed number of wait states.
// A read is accepted in IDLE, waits LATENCY cycles, then presents registered
// data with mem_ready held until the controller drops mem_cs. A side-band
// load port writes the array in any state.
module simple_memory_device #(
  parameter int size    = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  simple_memory_device_if.slave  bus,
  input  logic                   load_en,
  input  logic [size-1:0]        load_addr,
  input  logic [size-1:0]        load_data
);

  localparam int              aw        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**size still compares correctly.
  localparam logic [size:0]   depth_lim = (size + 1)'(DEPTH);
  localparam logic            zero_lat  = (LATENCY == 0);
  localparam logic [3:0]      wait_init = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t          state;
  logic [size-1:0] addr_q;
  logic [3:0]      wait_cnt;
  logic [size-1:0] data_q;
  logic            ready_q;
  logic            err_q;

  logic [size-1:0] mem [DEPTH];

  logic [size-1:0] cap_addr;
  logic            cap_in_range;
  logic [size-1:0] cap_data;
  logic            load_in_range;

  // Address feeding the data capture: the live bus when READY is entered
  // straight from IDLE (zero latency), otherwise the address held since acceptance.
  always_comb begin
    cap_addr     = (state == IDLE) ? bus.mem_addr_bus : addr_q;
    cap_in_range = ({1'b0, cap_addr} < depth_lim);
    cap_data     = cap_in_range ? mem[cap_addr[aw-1:0]] : '0;
  end

  assign load_in_range = ({1'b0, load_addr} < depth_lim);

  // Load port write; out-of-range loads are dropped.
  // NOTE: the array has no reset, so it maps onto plain RAM; a reset here
  // would force it into thousands of flops.
  always_ff @(posedge clk) begin
    if (load_en && load_in_range) begin
      mem[load_addr[aw-1:0]] <= load_data;
    end
  end

  // Access FSM with registered ready/data/error outputs.
  // NOTE: non-blocking assignments here mean a load on the capture edge is not
  // yet visible to cap_data, so that capture returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b0;
          // Writes through the controller bus are unsupported and ignored.
          if (bus.mem_cs && bus.mem_read) begin
            addr_q <= bus.mem_addr_bus;
            if (zero_lat) begin
              data_q <= cap_data;
              err_q  <= ~cap_in_range;
              state  <= READY;
            end else begin
              wait_cnt <= wait_init;
              state    <= WAIT;
            end
          end
        end

        WAIT: begin
          if (!bus.mem_cs) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            data_q <= cap_data;
            err_q  <= ~cap_in_range;
            state  <= READY;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        READY: begin
          if (!bus.mem_cs) begin
            ready_q <= 1'b0;
            state   <= IDLE;
          end else begin
            ready_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_data_bus = data_q;
  assign bus.mem_ready    = ready_q;
  assign bus.mem_err      = err_q;

endmodule
